poly_eval_driver: RTL and testbench



---
 rtl/poly_eval_pkg.sv | 21 ++
 rtl/poly_eval_refmodel.sv | 27 ++
 rtl/poly_eval_driver.sv | 170 +++++++++++++++++
 tb/tb_poly_eval_driver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and constants for the quadratic-evaluator load driver.
package poly_eval_pkg;

    // Default operand/result width.
    localparam int unsigned DefaultWidth = 8;

    // Operand replay order on the Go/DataIn handshake.
    localparam logic [1:0] IdxA = 2'd0;
    localparam logic [1:0] IdxB = 2'd1;
    localparam logic [1:0] IdxC = 2'd2;
    localparam logic [1:0] IdxX = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDriveHi,
        StDriveLo,
        StWaitCalc,
        StCapture
    } state_e;

endpackage

// File: rtl/poly_eval_refmodel.sv
// Expected evaluator result using the evaluator's own truncation order:
// ((A*x mod 2^W)*x + (B*x mod 2^W) + C) mod 2^W.
module poly_eval_refmodel
    import poly_eval_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
    input  logic [Width-1:0] coef_a_i,
    input  logic [Width-1:0] coef_b_i,
    input  logic [Width-1:0] coef_c_i,
    input  logic [Width-1:0] x_i,
    output logic [Width-1:0] expected_o
);

    logic [Width-1:0] ax;
    logic [Width-1:0] axx;
    logic [Width-1:0] bx;

    // Each product is truncated to Width bits by its assignment context.
    always_comb begin
        ax         = coef_a_i * x_i;
        axx        = ax * x_i;
        bx         = coef_b_i * x_i;
        expected_o = axx + bx + coef_c_i;
    end

endmodule

// File: rtl/poly_eval_driver.sv
// Initiator for the evaluator's Go/DataIn load handshake: latches A, B, C, x on
// start_i, replays them as four Go pulses, waits the compute latency, then
// captures data_result_i and pulses done_o as result_o updates.
// The evaluator must share rst_i (inverted to its active-low reset at system top).
// Optional POLY_EVAL_DRIVER_SELFCHECK_EN adds a sticky mismatch_o flag.
module poly_eval_driver
    import poly_eval_pkg::*;
#(
    parameter int unsigned Width        = DefaultWidth,
    parameter int unsigned GoHighCycles = 2,
    parameter int unsigned GoLowCycles  = 2,
    parameter int unsigned CalcLatency  = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] coef_a_i,
    input  logic [Width-1:0] coef_b_i,
    input  logic [Width-1:0] coef_c_i,
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] data_result_i,
    output logic             go_o,
    output logic [Width-1:0] data_in_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
    ,
    output logic             mismatch_o
`endif
);

    localparam int unsigned MaxHiLo   = (GoHighCycles > GoLowCycles) ? GoHighCycles : GoLowCycles;
    localparam int unsigned MaxCycles = (CalcLatency > MaxHiLo) ? CalcLatency : MaxHiLo;
    localparam int unsigned TimerW    = $clog2(MaxCycles) + 1;

    // Timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [TimerW-1:0] HiLoad   = TimerW'(GoHighCycles - 1);
    localparam logic [TimerW-1:0] LoLoad   = TimerW'(GoLowCycles - 1);
    localparam logic [TimerW-1:0] CalcLoad = TimerW'(CalcLatency - 1);

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [TimerW-1:0]       timer_q, timer_d;
    logic [3:0][Width-1:0]   ops_q, ops_d;
    logic                    go_q, go_d;
    logic [Width-1:0]        data_in_q, data_in_d;
    logic [Width-1:0]        result_q, result_d;
    logic                    done_q, done_d;

    // Next-state, operand sequencing and output register updates.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = (timer_q != '0) ? timer_q - TimerW'(1) : timer_q;
        ops_d     = ops_q;
        go_d      = go_q;
        data_in_d = data_in_q;
        result_d  = result_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    ops_d     = {x_i, coef_c_i, coef_b_i, coef_a_i};
                    state_d   = StDriveHi;
                    idx_d     = IdxA;
                    timer_d   = HiLoad;
                    go_d      = 1'b1;
                    // Operands are not latched yet, so drive A straight from the port.
                    data_in_d = coef_a_i;
                end
            end
            StDriveHi: begin
                if (timer_q == '0) begin
                    state_d = StDriveLo;
                    timer_d = LoLoad;
                    go_d    = 1'b0;
                end
            end
            StDriveLo: begin
                if (timer_q == '0) begin
                    if (idx_q == IdxX) begin
                        state_d = StWaitCalc;
                        timer_d = CalcLoad;
                    end else begin
                        state_d   = StDriveHi;
                        idx_d     = idx_q + 2'd1;
                        timer_d   = HiLoad;
                        go_d      = 1'b1;
                        data_in_d = ops_q[idx_q + 2'd1];
                    end
                end
            end
            StWaitCalc: begin
                if (timer_q == '0) begin
                    state_d = StCapture;
                    timer_d = '0;
                end
            end
            StCapture: begin
                result_d  = data_result_i;
                done_d    = 1'b1;
                state_d   = StIdle;
                idx_d     = IdxA;
                timer_d   = '0;
                data_in_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= IdxA;
            timer_q   <= '0;
            ops_q     <= '0;
            go_q      <= 1'b0;
            data_in_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            ops_q     <= ops_d;
            go_q      <= go_d;
            data_in_q <= data_in_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign go_o      = go_q;
    assign data_in_o = data_in_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign result_o  = result_q;

`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
    logic [Width-1:0] expected;
    logic             mismatch_q;

    poly_eval_refmodel #(
        .Width (Width)
    ) u_refmodel (
        .coef_a_i   (ops_q[IdxA]),
        .coef_b_i   (ops_q[IdxB]),
        .coef_c_i   (ops_q[IdxC]),
        .x_i        (ops_q[IdxX]),
        .expected_o (expected)
    );

    // Sticky flag: set on any capture that disagrees with the expected value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
        end else if (state_q == StCapture && expected != data_result_i) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch_o = mismatch_q;
`endif

endmodule

// File: tb/tb_poly_eval_driver.sv
// Self-checking bench: a behavioural evaluator answers each DUT's Go pulses,
// and results/latency/pulse shape are compared against plain arithmetic.
module tb_poly_eval_driver;

    localparam int unsigned LatDef  = 4 * (2 + 2) + 6 + 1;
    localparam int unsigned LatFast = 4 * (1 + 1) + 5 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start_f;
    logic [7:0] a, b, c, x;
    logic       force_bad;
    logic [7:0] eval_res, eval_res_f, dres, dres_f;

    logic       go, busy, done, go_f, busy_f, done_f;
    logic [7:0] din, res, din_f, res_f;
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
    logic       mism, mism_f;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign dres   = force_bad ? 8'hFF : eval_res;
    assign dres_f = eval_res_f;

    poly_eval_driver u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .coef_a_i      (a),
        .coef_b_i      (b),
        .coef_c_i      (c),
        .x_i           (x),
        .data_result_i (dres),
        .go_o          (go),
        .data_in_o     (din),
        .busy_o        (busy),
        .done_o        (done),
        .result_o      (res)
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
        ,
        .mismatch_o    (mism)
`endif
    );

    poly_eval_driver #(
        .GoHighCycles (1),
        .GoLowCycles  (1),
        .CalcLatency  (5)
    ) u_dut_fast (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start_f),
        .coef_a_i      (a),
        .coef_b_i      (b),
        .coef_c_i      (c),
        .x_i           (x),
        .data_result_i (dres_f),
        .go_o          (go_f),
        .data_in_o     (din_f),
        .busy_o        (busy_f),
        .done_o        (done_f),
        .result_o      (res_f)
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
        ,
        .mismatch_o    (mism_f)
`endif
    );

    function automatic logic [7:0] poly_ref(input logic [7:0] pa, pb, pc, px);
        int r;
        r = int'(pa) * int'(px) * int'(px) + int'(pb) * int'(px) + int'(pc);
        return 8'(r % 256);
    endfunction

    // Behavioural evaluators: take operands on Go rising edges in order A, B, C, x.
    logic [7:0] eops [4];
    int         ecnt;
    logic       ego_d1;
    always @(posedge clk) begin
        if (rst) begin
            ecnt <= 0; eval_res <= 8'd0; ego_d1 <= 1'b0;
        end else begin
            if (go && !ego_d1) begin
                eops[ecnt] <= din;
                if (ecnt == 3) eval_res <= poly_ref(eops[0], eops[1], eops[2], din);
                ecnt <= (ecnt == 3) ? 0 : ecnt + 1;
            end
            ego_d1 <= go;
        end
    end

    logic [7:0] fops [4];
    int         fcnt;
    logic       fgo_d1;
    always @(posedge clk) begin
        if (rst) begin
            fcnt <= 0; eval_res_f <= 8'd0; fgo_d1 <= 1'b0;
        end else begin
            if (go_f && !fgo_d1) begin
                fops[fcnt] <= din_f;
                if (fcnt == 3) eval_res_f <= poly_ref(fops[0], fops[1], fops[2], din_f);
                fcnt <= (fcnt == 3) ? 0 : fcnt + 1;
            end
            fgo_d1 <= go_f;
        end
    end

    // Pulse monitor on the default DUT: value at each Go rise, high length, stability.
    logic [7:0] pulse_q [$];
    int         hilen_q [$];
    int         hi_len = 0;
    logic [7:0] hi_val = 8'd0;
    int         stab_err = 0;
    logic       go_prev_m = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pulse_q.delete();
            hilen_q.delete();
            go_prev_m <= 1'b0;
            hi_len    <= 0;
        end else begin
            if (go && !go_prev_m) begin
                pulse_q.push_back(din);
                hi_val <= din;
                hi_len <= 1;
            end else if (go) begin
                hi_len <= hi_len + 1;
                if (din !== hi_val) stab_err <= stab_err + 1;
            end else if (go_prev_m) begin
                hilen_q.push_back(hi_len);
            end
            go_prev_m <= go;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit fast, input logic [7:0] ra, rb, rc, rx, input int exp_lat,
                          input bit poke, input logic [7:0] exp_res, input bit exp_mism);
        int   cyc;
        bit   seen, busy_ok;
        int   base_p, base_h, base_e;
        logic [7:0] ops [4];
        ops[0] = ra; ops[1] = rb; ops[2] = rc; ops[3] = rx;
        @(posedge clk);
        base_p = pulse_q.size(); base_h = hilen_q.size(); base_e = stab_err;
        @(negedge clk);
        a = ra; b = rb; c = rc; x = rx;
        if (fast) start_f = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start_f = 1'b0;
        // Later operand changes must not leak into the run.
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
        busy_ok = (fast ? busy_f : busy);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 100) begin
            if (poke) start = (cyc == 4 || cyc == 22);
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (fast ? done_f : done) seen = 1'b1;
            else if (!(fast ? busy_f : busy)) busy_ok = 1'b0;
        end
        start = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("result", 32'(fast ? res_f : res), 32'(exp_res));
        check_eq("busy_during_run", 32'(busy_ok), 32'd1);
        check_eq("busy_after", 32'(fast ? busy_f : busy), 32'd0);
        check_eq("data_in_idle", 32'(fast ? din_f : din), 32'd0);
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
        check_eq("mismatch", 32'(fast ? mism_f : mism), 32'(exp_mism));
`endif
        if (!fast) begin
            check_eq("go_pulse_count", 32'(pulse_q.size() - base_p), 32'd4);
            check_eq("go_fall_count", 32'(hilen_q.size() - base_h), 32'd4);
            for (int i = 0; i < 4 && base_p + i < pulse_q.size(); i++)
                check_eq($sformatf("pulse_val%0d", i), 32'(pulse_q[base_p + i]), 32'(ops[i]));
            for (int i = 0; i < 4 && base_h + i < hilen_q.size(); i++)
                check_eq($sformatf("pulse_len%0d", i), 32'(hilen_q[base_h + i]), 32'd2);
            check_eq("data_in_stable", 32'(stab_err - base_e), 32'd0);
        end
        @(negedge clk);
        check_eq("done_one_cycle", 32'(fast ? done_f : done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra_done, extra_busy;
        logic [7:0] ra, rb, rc, rx;
        rst = 1'b1; start = 1'b0; start_f = 1'b0; force_bad = 1'b0;
        a = 8'd0; b = 8'd0; c = 8'd0; x = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_go", 32'(go), 32'd0);
        check_eq("rst_din", 32'(din), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", 32'(res), 32'd0);
        check_eq("rst_fast_busy", 32'(busy_f), 32'd0);
`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
        check_eq("rst_mismatch", 32'(mism), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(0, 8'd3, 8'd5, 8'd7, 8'd2, LatDef, 0, 8'd29, 0);
        run_op(0, 8'd1, 8'd1, 8'd1, 8'd20, LatDef, 0, 8'd165, 0);

        // Start pokes mid-run and during CAPTURE are dropped.
        run_op(0, 8'd9, 8'd4, 8'd11, 8'd6, LatDef, 1, poly_ref(8'd9, 8'd4, 8'd11, 8'd6), 0);
        extra_done = 0; extra_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check_eq("no_queued_done", 32'(extra_done), 32'd0);
        check_eq("no_queued_busy", 32'(extra_busy), 32'd0);

        // Reset in the middle of a run.
        @(negedge clk);
        a = 8'd10; b = 8'd20; c = 8'd30; x = 8'd40; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_go", 32'(go), 32'd0);
        check_eq("midrst_din", 32'(din), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_result", 32'(res), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, 8'd2, 8'd0, 8'd4, 8'd3, LatDef, 0, 8'd22, 0);

        run_op(1, 8'd3, 8'd5, 8'd7, 8'd2, LatFast, 0, 8'd29, 0);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rx = 8'($urandom);
            run_op(1, ra, rb, rc, rx, LatFast, 0, poly_ref(ra, rb, rc, rx), 0);
        end
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rx = 8'($urandom);
            run_op(0, ra, rb, rc, rx, LatDef, 0, poly_ref(ra, rb, rc, rx), 0);
        end

`ifdef POLY_EVAL_DRIVER_SELFCHECK_EN
        // A corrupted evaluator result raises the sticky flag until reset.
        force_bad = 1'b1;
        run_op(0, 8'd3, 8'd5, 8'd7, 8'd2, LatDef, 0, 8'hFF, 1);
        force_bad = 1'b0;
        run_op(0, 8'd1, 8'd2, 8'd3, 8'd4, LatDef, 0, poly_ref(8'd1, 8'd2, 8'd3, 8'd4), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mismatch_cleared", 32'(mism), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
